// File: rtl/pull_bus_arb.sv
// Round-robin owner of a shared tristate bus with turnaround gaps and a pull-up, pull-down or keeper idle level.
// Grant is registered one cycle after req. The owner keeps the bus until it drops req, or until MAX_HOLD expires while others wait.
module pull_bus_arb #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int PULL_MODE = 1,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 4,
  parameter logic [W-1:0] KEEP_INIT = '0,
  localparam int OW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  wdata,
  output logic [N-1:0]    grant,
  output logic [OW-1:0]   owner,
  output logic            busy,
  inout  wire  [W-1:0]    bus,
  output logic [W-1:0]    bus_val,
  output logic            coll_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [7:0]      hold_cnt;
  logic [3:0]      turn_cnt;
  logic [W-1:0]    keeper;

  logic [W-1:0]    ch_dat [N];
  logic [W-1:0]    drv_dat;
  logic [W-1:0]    pull_val;
  logic [OW-1:0]   win;
  logic [OW-1:0]   idx;
  logic            found;
  logic            drive;
  logic            own_req;
  logic            others;
  logic            leave;
  logic            arb_now;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_dat[i] = wdata[i*W +: W];
  end

  assign drv_dat = ch_dat[owner];
  assign drive   = (state == DRIVE);

  // Scan upward from the channel after the last winner, wrapping past N-1.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = OW'((int'(rr_ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // grant is one-hot on the owner throughout DRIVE.
  assign own_req = |(req & grant);
  assign others  = |(req & ~grant);
  assign leave   = !own_req || ((hold_cnt == HOLD_MAX) && others);
  assign arb_now = (state == IDLE) ||
                   ((state == TURN) && (turn_cnt == 4'd0)) ||
                   (drive && leave && (TURN_CYC == 0));

  assign pull_val = (PULL_MODE == 0) ? '0 : (PULL_MODE == 1) ? '1 : keeper;

  // The pull side steps aside while the owner drives; a strong driver wins either way.
  assign bus = drive ? drv_dat : {W{1'bz}};
  assign (pull1, pull0) bus = drive ? {W{1'bz}} : pull_val;
  assign bus_val = bus;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      coll_err <= 1'b0;
      rr_ptr   <= OW'(N - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      keeper   <= KEEP_INIT;
    end else begin
      if (drive) begin
        keeper <= bus_val;
        // An X or Z compare falls into the else branch and flags a collision.
        if (bus_val == drv_dat) coll_err <= coll_err;
        else                    coll_err <= 1'b1;
      end

      if (arb_now) begin
        if (found) begin
          state    <= DRIVE;
          grant    <= N'(1) << win;
          owner    <= win;
          rr_ptr   <= win;
          hold_cnt <= '0;
          busy     <= 1'b1;
        end else begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      end else if (drive && leave) begin
        state    <= TURN;
        grant    <= '0;
        turn_cnt <= 4'(TURN_CYC - 1);
      end else if (drive) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
      end else if (state == TURN) begin
        turn_cnt <= turn_cnt - 4'd1;
      end
    end
  end

endmodule
